// File: rtl/pc_sequencer.sv
// pc_sequencer: MIPS program counter and instruction-fetch sequencer.
// Picks the next PC (exception, eret, branch, jump, PC+4) and runs the fetch handshake.
module pc_sequencer #(
  parameter int N = 32,
  parameter logic [N-1:0] RESET_PC = 32'h0040_0000,
  parameter logic [N-1:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall_i,
  input  logic         imem_ack_i,
  input  logic         branch_taken_i,
  input  logic [N-1:0] branch_target_i,
  input  logic         jump_i,
  input  logic [N-1:0] jump_target_i,
  input  logic         exception_i,
  input  logic         eret_i,
  output logic [N-1:0] pc_o,
  output logic [N-1:0] pc_plus4_o,
  output logic         imem_req_o,
  output logic         valid_o,
  output logic         flush_o,
  output logic [N-1:0] epc_o,
  output logic         misalign_o,
  output logic [31:0]  fetch_count_o
);
  typedef enum logic [1:0] {BOOT, FETCH, REDIRECT} state_t;
  state_t state;
  logic redirect, misalign_next;
  logic [N-1:0] target;
  assign redirect = exception_i | eret_i | branch_taken_i | jump_i;
  assign valid_o = (state == FETCH) && imem_ack_i && !stall_i && !redirect;
  assign pc_plus4_o = pc_o + N'(4);
  // Branch and jump targets are word-aligned by dropping the low two bits.
  always_comb begin
    target = exception_i ? EXC_VECTOR :
             eret_i ? epc_o :
             branch_taken_i ? {branch_target_i[N-1:2], 2'b00} :
             {jump_target_i[N-1:2], 2'b00};
    misalign_next = !exception_i && !eret_i &&
                    (branch_taken_i ? |branch_target_i[1:0] : jump_i && |jump_target_i[1:0]);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
      pc_o <= RESET_PC;
      epc_o <= '0;
      imem_req_o <= 1'b0;
      flush_o <= 1'b0;
      misalign_o <= 1'b0;
      fetch_count_o <= '0;
    end else begin
      state <= redirect ? REDIRECT : FETCH;
      imem_req_o <= !redirect;
      pc_o <= redirect ? target : valid_o ? pc_plus4_o : pc_o;
      if (exception_i) epc_o <= pc_o;
      flush_o <= redirect;
      misalign_o <= misalign_next;
      fetch_count_o <= fetch_count_o + {31'b0, valid_o};
    end
  end
endmodule
